// File: rtl/spi_burst_dispatch.sv
// spi_burst_dispatch: queues SPI read/write burst commands and issues them one
// at a time to the RAM controller, guarding each burst with a WAIT watchdog.
module spi_burst_dispatch #(
    parameter int unsigned           CTRL_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [CTRL_WIDTH-1:0] CTRL_WRITE  = 8'h3a,
    parameter logic [CTRL_WIDTH-1:0] CTRL_READ   = 8'h3b,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [15:0]           TIMEOUT     = 16'd4096
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  hbc_cal_pass,
    input  logic                  spi_done,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  ram_idle,
    input  logic                  ram_done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rdwr,
    output logic                  busy,
    output logic                  cmd_drop,
    output logic                  timeout_err
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
    // timeout_err is registered, so expiry is decided one count early; this
    // places the pulse exactly TIMEOUT cycles after the ram_en strobe.
    localparam logic [15:0] WD_LAST = TIMEOUT - 16'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [15:0]         wd;
    logic                is_read;
    logic                legal;
    logic                full;
    logic                pop;
    logic                accept;
    logic                push;
    logic                drop;

    assign is_read = (ctrl == CTRL_READ);
    assign legal   = (ctrl == CTRL_WRITE) || is_read;
    assign full    = (count == FULL_CNT);
    // The head leaves the queue on the edge that ends the ISSUE cycle.
    assign pop     = (state == ISSUE);
    assign accept  = spi_done && hbc_cal_pass;
    assign push    = accept && legal && (!full || pop);
    assign drop    = accept && !(legal && (!full || pop));
    assign busy    = (state != IDLE) || (count != '0);

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= {is_read, address};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cmd_drop <= 1'b0;
        end else begin
            cmd_drop <= drop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            wd          <= '0;
            ram_en      <= 1'b0;
            ram_addr    <= '0;
            ram_rdwr    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ram_en      <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if ((count != '0) && ram_idle) begin
                        state                <= ISSUE;
                        ram_en               <= 1'b1;
                        {ram_rdwr, ram_addr} <= mem[rd_ptr];
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    wd    <= '0;
                end
                WAIT: begin
                    if (ram_done) begin
                        state <= IDLE;
                        wd    <= '0;
                    end else if (wd == WD_LAST) begin
                        state       <= IDLE;
                        wd          <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_burst_dispatch.sv
// Bench for spi_burst_dispatch: a transaction-level model predicts every output
// each cycle, and directed scenarios pin latencies, ordering and counts.
module tb_spi_burst_dispatch;
    localparam int TMO = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        hbc_cal_pass = 1'b1;
    logic        spi_done = 1'b0;
    logic [7:0]  ctrl = 8'h00;
    logic [31:0] address = 32'h0;
    logic        ram_idle = 1'b0;
    logic        ram_done = 1'b0;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic        ram_rdwr;
    logic        busy;
    logic        cmd_drop;
    logic        timeout_err;

    spi_burst_dispatch #(
        .CTRL_WIDTH(8), .ADDR_WIDTH(32), .CTRL_WRITE(8'h3a), .CTRL_READ(8'h3b),
        .QUEUE_DEPTH(4), .TIMEOUT(16'd16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hbc_cal_pass(hbc_cal_pass),
        .spi_done(spi_done), .ctrl(ctrl), .address(address), .ram_idle(ram_idle),
        .ram_done(ram_done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdwr(ram_rdwr),
        .busy(busy), .cmd_drop(cmd_drop), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    bit started = 0;
    int edge_n = 0;
    int frame_edge = 0;
    int en_cnt = 0;
    int drop_cnt = 0;
    int to_cnt = 0;
    int to_edge = 0;
    logic [32:0] issued [$];
    int en_edge [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] get_issued(input int i);
        return (i < issued.size()) ? issued[i] : 33'h1_ffff_ffff;
    endfunction

    function automatic int get_en_edge(input int i);
        return (i < en_edge.size()) ? en_edge[i] : -1000;
    endfunction

    // Model: pending commands, whether a request is outstanding, and its age.
    logic [32:0] mq [$];
    bit          m_out = 0;
    bit          m_en = 0;
    bit          m_drop = 0;
    bit          m_to = 0;
    int          m_age = 0;
    logic [31:0] m_addr = 32'h0;
    logic        m_rdwr = 1'b0;

    always @(posedge sys_clk) edge_n++;

    always @(posedge sys_clk) begin : model
        bit en_n, fin, lgl, psh;
        if (sys_rst) begin
            mq.delete();
            m_out = 0; m_en = 0; m_drop = 0; m_to = 0; m_age = 0;
            m_addr = 32'h0; m_rdwr = 1'b0;
        end else begin
            m_to   = m_out && !m_en && !ram_done && (m_age == TMO - 1);
            fin    = m_out && !m_en && (ram_done || m_to);
            en_n   = !m_out && (mq.size() > 0) && ram_idle;
            lgl    = (ctrl == 8'h3a) || (ctrl == 8'h3b);
            psh    = spi_done && hbc_cal_pass && lgl && ((mq.size() < 4) || m_en);
            m_drop = spi_done && hbc_cal_pass && !psh;
            if (en_n) begin
                m_addr = mq[0][31:0];
                m_rdwr = mq[0][32];
            end
            if (m_en) void'(mq.pop_front());
            if (psh) mq.push_back({ctrl == 8'h3b, address});
            m_out = en_n || (m_out && !fin);
            m_age = en_n ? 0 : m_age + 1;
            m_en  = en_n;
        end
    end

    always @(negedge sys_clk) begin : compare
        if (started) begin
            if (sys_rst) begin
                chk("rst_ram_en", ram_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ram_addr", ram_addr, 0);
            end else begin
                chk("ram_en", ram_en, m_en);
                chk("ram_addr", ram_addr, m_addr);
                chk("ram_rdwr", ram_rdwr, m_rdwr);
                chk("busy", busy, (m_out || mq.size() != 0) ? 1 : 0);
                chk("cmd_drop", cmd_drop, m_drop);
                chk("timeout_err", timeout_err, m_to);
            end
            if (ram_en) begin
                issued.push_back({ram_rdwr, ram_addr});
                en_edge.push_back(edge_n);
                en_cnt++;
            end
            if (cmd_drop) drop_cnt++;
            if (timeout_err) begin
                to_cnt++;
                to_edge = edge_n;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] c, input logic [31:0] a, input logic cal);
        spi_done = 1'b1; ctrl = c; address = a; hbc_cal_pass = cal;
        frame_edge = edge_n;
        tick();
        spi_done = 1'b0; hbc_cal_pass = 1'b1; ctrl = 8'h00;
    endtask

    task automatic wait_issue(input int target, input int bound);
        int n = 0;
        while (en_cnt < target && n < bound) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        if (en_cnt < target) begin
            errors++;
            checks++;
            $display("FAIL wait_issue: got %0d requests expected %0d", en_cnt, target);
        end
        tick();
    endtask

    task automatic serve(input int target);
        wait_issue(target, 40);
        ram_done = 1'b1;
        tick();
        ram_done = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int base, d0, t0, n;
        logic [32:0] ord_exp [4];
        ord_exp[0] = 33'h0_0000_0000; ord_exp[1] = 33'h0_0000_0040;
        ord_exp[2] = 33'h1_0000_0000; ord_exp[3] = 33'h1_0000_0040;

        #3 sys_rst = 1'b1;
        started = 1;
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_ram_en", ram_en, 0);
        chk("reset_addr", ram_addr, 0);
        sys_rst = 1'b0;
        tick();

        // single write
        ram_idle = 1'b1;
        base = en_cnt;
        frame(8'h3a, 32'h40, 1'b1);
        wait_issue(base + 1, 10);
        chk("single_latency", get_en_edge(base) - frame_edge, 2);
        chk("single_req", get_issued(base), 33'h0_0000_0040);
        chk("single_busy_wait", busy, 1);
        ram_done = 1'b1; tick(); ram_done = 1'b0;
        chk("single_busy_done", busy, 0);

        // ordering
        ram_idle = 1'b0;
        base = en_cnt;
        frame(8'h3a, 32'h0, 1'b1);
        frame(8'h3a, 32'h40, 1'b1);
        frame(8'h3b, 32'h0, 1'b1);
        frame(8'h3b, 32'h40, 1'b1);
        ram_idle = 1'b1;
        for (int k = 0; k < 4; k++) serve(base + k + 1);
        for (int k = 0; k < 4; k++) chk($sformatf("order_%0d", k), get_issued(base + k), ord_exp[k]);

        // overflow
        ram_idle = 1'b0;
        base = en_cnt; d0 = drop_cnt;
        for (int k = 0; k < 5; k++) frame(8'h3a, 32'h100 + k, 1'b1);
        tick();
        chk("overflow_drop", drop_cnt - d0, 1);
        ram_idle = 1'b1;
        for (int k = 0; k < 4; k++) serve(base + k + 1);
        repeat (8) tick();
        chk("overflow_issued", en_cnt - base, 4);
        chk("overflow_last", get_issued(base + 3), 33'h0_0000_0103);

        // illegal opcode, then gated by calibration, then stray ram_done
        base = en_cnt; d0 = drop_cnt;
        frame(8'h55, 32'h200, 1'b1);
        repeat (6) tick();
        chk("illegal_drop", drop_cnt - d0, 1);
        chk("illegal_noreq", en_cnt - base, 0);
        frame(8'h3a, 32'h300, 1'b0);
        repeat (6) tick();
        chk("gated_drop", drop_cnt - d0, 1);
        chk("gated_noreq", en_cnt - base, 0);
        ram_done = 1'b1; tick(); ram_done = 1'b0;
        repeat (3) tick();
        chk("stray_done_busy", busy, 0);

        // push into a full queue in the cycle the head pops
        ram_idle = 1'b0;
        base = en_cnt; d0 = drop_cnt;
        for (int k = 0; k < 4; k++) frame(8'h3b, 32'h500 + k, 1'b1);
        ram_idle = 1'b1;
        tick();
        chk("full_issue_now", ram_en, 1);
        frame(8'h3a, 32'h504, 1'b1);
        for (int k = 0; k < 5; k++) serve(base + k + 1);
        chk("full_pushpop_drop", drop_cnt - d0, 0);
        chk("full_pushpop_issued", en_cnt - base, 5);
        chk("full_pushpop_last", get_issued(base + 4), 33'h0_0000_0504);

        // watchdog
        ram_idle = 1'b0;
        base = en_cnt; t0 = to_cnt;
        frame(8'h3a, 32'h600, 1'b1);
        frame(8'h3b, 32'h604, 1'b1);
        ram_idle = 1'b1;
        wait_issue(base + 1, 10);
        n = 0;
        while (to_cnt == t0 && n < 40) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk("wd_fired", to_cnt - t0, 1);
        chk("wd_delay", to_edge - get_en_edge(base), 16);
        chk("wd_hold_addr", ram_addr, 32'h600);
        serve(base + 2);
        chk("wd_next_req", get_issued(base + 1), 33'h1_0000_0604);

        // reset mid-burst with two entries queued
        ram_idle = 1'b0;
        base = en_cnt; t0 = to_cnt;
        frame(8'h3b, 32'h700, 1'b1);
        frame(8'h3a, 32'h704, 1'b1);
        frame(8'h3a, 32'h708, 1'b1);
        ram_idle = 1'b1;
        wait_issue(base + 1, 10);
        tick();
        chk("pre_rst_rdwr", ram_rdwr, 1);
        sys_rst = 1'b1;
        #1;
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_addr", ram_addr, 0);
        chk("midrst_rdwr", ram_rdwr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_drop", cmd_drop, 0);
        chk("midrst_to", timeout_err, 0);
        tick();
        sys_rst = 1'b0;
        ram_done = 1'b1; tick(); ram_done = 1'b0;
        repeat (24) tick();
        chk("rst_no_issue", en_cnt - base, 1);
        chk("rst_no_timeout", to_cnt - t0, 0);
        frame(8'h3b, 32'h800, 1'b1);
        serve(base + 2);
        chk("rst_new_req", get_issued(base + 1), 33'h1_0000_0800);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_burst_dispatch.md
SPI_BURST_DISPATCH -- requirements
Module: spi_burst_dispatch

Interface
REQ-001 The block SHALL have parameter CTRL_WIDTH, default 8, meaning the command byte width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the burst address width.
REQ-003 The block SHALL have parameter CTRL_WRITE, default 8'h3a, meaning the write opcode.
REQ-004 The block SHALL have parameter CTRL_READ, default 8'h3b, meaning the read opcode.
REQ-005 The block SHALL have parameter QUEUE_DEPTH, default 4, meaning command queue entries (power of 2, at least 2).
REQ-006 The block SHALL have parameter TIMEOUT, default 16'd4096, meaning the maximum number of WAIT cycles.
REQ-007 The block SHALL have port sys_clk, input, 1 bit, the clock.
REQ-008 The block SHALL have port sys_rst, input, 1 bit, an asynchronous active-high reset.
REQ-009 The block SHALL have port hbc_cal_pass, input, 1 bit; RAM calibration done, gates command acceptance.
REQ-010 The block SHALL have port spi_done, input, 1 bit; single-cycle pulse from the SPI slave meaning a frame is complete.
REQ-011 The block SHALL have port ctrl, input, CTRL_WIDTH bits; frame opcode, valid while spi_done is high.
REQ-012 The block SHALL have port address, input, ADDR_WIDTH bits; frame address, valid while spi_done is high.
REQ-013 The block SHALL have port ram_idle, input, 1 bit; RAM controller ready for a request.
REQ-014 The block SHALL have port ram_done, input, 1 bit; single-cycle pulse meaning the burst is complete.
REQ-015 The block SHALL have port ram_en, output, 1 bit; single-cycle request strobe.
REQ-016 The block SHALL have port ram_addr, output, ADDR_WIDTH bits; request address.
REQ-017 The block SHALL have port ram_rdwr, output, 1 bit; 1 = read, 0 = write.
REQ-018 The block SHALL have port busy, output, 1 bit; high when the FSM is not in IDLE or the queue is non-empty.
REQ-019 The block SHALL have port cmd_drop, output, 1 bit; single-cycle pulse when a command is rejected.
REQ-020 The block SHALL have port timeout_err, output, 1 bit; single-cycle pulse when the WAIT watchdog expires.

Function
REQ-021 Push: on spi_done=1 with hbc_cal_pass=1 and ctrl equal to CTRL_WRITE or CTRL_READ, the block SHALL enqueue {rdwr, address}, with rdwr=1 for CTRL_READ.
REQ-022 On spi_done=1 with hbc_cal_pass=0, the block SHALL discard the command silently: no push, no cmd_drop.
REQ-023 On spi_done=1 with an illegal ctrl, or with the queue full and no pop in the same cycle, the block SHALL pulse cmd_drop on the next cycle and leave the queue unchanged.
REQ-024 A push and a pop in the same cycle SHALL both succeed, including when the queue is full, and the entry count SHALL stay unchanged.
REQ-025 The queue SHALL be FIFO-ordered, with read/write pointers wrapping modulo QUEUE_DEPTH and count ranging 0..QUEUE_DEPTH.
REQ-026 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-027 IDLE->ISSUE SHALL occur when the queue is non-empty and ram_idle=1; otherwise the FSM SHALL stay in IDLE.
REQ-028 In ISSUE, for exactly one cycle, the block SHALL drive ram_en=1 with ram_addr/ram_rdwr set to the queue head, pop the head, and go to WAIT.
REQ-029 ram_addr and ram_rdwr SHALL be registered and SHALL hold their last issued values outside ISSUE.
REQ-030 In WAIT, ram_done=1 SHALL cause a return to IDLE, and the watchdog counter SHALL clear.
REQ-031 In WAIT, the watchdog SHALL count sys_clk cycles; on reaching TIMEOUT-1 with no ram_done, the block SHALL pulse timeout_err and go to IDLE.
REQ-032 A ram_done that arrives outside WAIT SHALL be ignored.
REQ-033 Issue latency SHALL be: a push at cycle N into an empty queue, with the FSM in IDLE and ram_idle=1, gives ram_en=1 at cycle N+2.
REQ-034 Back-to-back requests SHALL have at least one IDLE cycle between a ram_done and the next ram_en.
REQ-035 A deassertion of hbc_cal_pass SHALL NOT flush the queue or abort an in-flight burst.

Reset
REQ-036 While sys_rst=1, the block SHALL hold the FSM in IDLE, clear the queue count and pointers, clear the watchdog, and drive ram_en, ram_rdwr, busy, cmd_drop and timeout_err to 0 and ram_addr to 0.
REQ-037 An asynchronous reset during WAIT SHALL discard the in-flight burst and all queued commands, with no pulses issued after release.

Verification
REQ-038 Single write: cal_pass=1, spi_done with ctrl=8'h3a, addr=32'h40, ram_idle=1 -> ram_en exactly 2 cycles later, ram_addr=32'h40, ram_rdwr=0; busy drops after ram_done.
REQ-039 Ordering: frames 3a@0, 3a@40, 3b@0, 3b@40 queued while ram_idle=0, then ram_idle=1 -> four ram_en strobes in the same order, with rdwr 0,0,1,1.
REQ-040 Overflow: 5 pushes with ram_idle=0 and QUEUE_DEPTH=4 -> exactly one cmd_drop pulse, and 4 requests issued later.
REQ-041 Illegal/gated commands: ctrl=8'h55 -> cmd_drop pulse, no request; ctrl=8'h3a with cal_pass=0 -> no cmd_drop, no request.
REQ-042 Watchdog: issue one request and withhold ram_done, TIMEOUT=16 -> timeout_err pulse 16 cycles after ram_en, FSM in IDLE, next queued command issues.
REQ-043 Reset mid-burst: sys_rst pulse during WAIT with 2 entries queued -> all outputs 0, busy=0, and no ram_en until a new push.
